// File: rtl/bcp_round_sched_pkg.sv
// Shared types and defaults for the BCP round scheduler.
// Literals are 11-bit two's complement (0 = empty slot); clauses hold three literals, slot 0 in the LSBs.
package bcp_round_sched_pkg;

    localparam int LIT_WIDTH      = 11;
    localparam int CLA_LENGTH     = 3;
    localparam int NUM_CLAUSE_DEF = 4;
    localparam int UCQ_DEPTH_DEF  = 8;
    localparam int DRAIN_MIN_DEF  = 2;

    typedef logic signed [LIT_WIDTH-1:0] lit_t;
    typedef lit_t [CLA_LENGTH-1:0]        cla_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_STREAM,
        ST_DRAIN,
        ST_SAT_DONE,
        ST_CONF_DONE
    } state_t;

endpackage

// File: rtl/bcp_round_sched_ucq.sv
// Pending unit-clause FIFO. Head/tail pointers carry one wrap bit.
// A flush clears the queue and may load a first entry in the same cycle.
module bcp_ucq #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      head;
    logic [AW:0]      tail;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    assign empty    = (head == tail);
    assign full     = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
    assign pop_data = mem[head[AW-1:0]];

    assign wr_en  = push && (flush || !full);
    assign wr_idx = flush ? '0 : tail[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= {{AW{1'b0}}, push};
        end else begin
            if (push && !full)
                tail <= tail + 1'b1;
            if (pop && !empty)
                head <= head + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/bcp_round_sched.sv
// Round sequencer for the BCP datapath: pops one unit clause per round, streams all
// clauses from clause memory behind it, then waits for the clause arbiter to drain.
module bcp_round_sched
    import bcp_round_sched_pkg::*;
#(
    parameter int NUM_CLAUSE = NUM_CLAUSE_DEF,
    parameter int UCQ_DEPTH  = UCQ_DEPTH_DEF,
    parameter int DRAIN_MIN  = DRAIN_MIN_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  lit_t                          init_uc,
    input  logic                          new_uc_valid,
    input  lit_t                          new_uc,
    output logic                          new_uc_ready,
    output logic                          mem_rd_en,
    output logic [$clog2(NUM_CLAUSE)-1:0] mem_rd_addr,
    input  cla_t                          mem_rd_data,
    output logic                          mem2carb_uc_valid,
    output lit_t                          mem2carb_uc,
    output logic                          mem2carb_start,
    output logic                          mem2carb_finish,
    output cla_t                          mem2carb_clause,
    input  logic                          carb_empty,
    input  logic                          conflict,
    output logic                          busy,
    output logic                          sat_done,
    output logic                          conf_done,
    output logic [15:0]                   round_cnt
);

    localparam int            AW        = $clog2(NUM_CLAUSE);
    localparam int            DW        = $clog2(DRAIN_MIN + 2);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_CLAUSE - 1);

    state_t        state, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          pend_q, pend_d;
    logic          pend_last_q, pend_last_d;
    logic          cnt_clr, cnt_inc;

    logic          q_flush, q_push, q_pop, q_full, q_empty;
    lit_t          q_push_data, q_head;

    bcp_ucq #(
        .DEPTH(UCQ_DEPTH),
        .WIDTH(LIT_WIDTH)
    ) u_ucq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (q_flush),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign busy         = (state == ST_POP) || (state == ST_STREAM) || (state == ST_DRAIN);
    assign sat_done     = (state == ST_SAT_DONE);
    assign conf_done    = (state == ST_CONF_DONE);
    assign new_uc_ready = !q_full;

    always_comb begin
        state_d           = state;
        addr_d            = addr_q;
        drain_d           = drain_q;
        cnt_clr           = 1'b0;
        cnt_inc           = 1'b0;
        q_flush           = 1'b0;
        q_pop             = 1'b0;
        q_push            = busy && new_uc_valid && !q_full && (new_uc != '0);
        q_push_data       = new_uc;
        mem_rd_en         = 1'b0;
        mem_rd_addr       = '0;
        mem2carb_uc_valid = 1'b0;
        mem2carb_uc       = '0;
        mem2carb_start    = 1'b0;
        mem2carb_finish   = 1'b0;
        mem2carb_clause   = '0;

        case (state)
            ST_IDLE, ST_SAT_DONE, ST_CONF_DONE: begin
                if (start_i) begin
                    state_d     = ST_POP;
                    cnt_clr     = 1'b1;
                    q_flush     = 1'b1;
                    q_push      = (init_uc != '0);
                    q_push_data = init_uc;
                end
            end
            ST_POP: begin
                if (q_empty) begin
                    state_d = ST_SAT_DONE;
                end else begin
                    q_pop             = 1'b1;
                    mem2carb_uc_valid = 1'b1;
                    mem2carb_uc       = q_head;
                    mem_rd_en         = 1'b1;
                    addr_d            = '0;
                    cnt_inc           = 1'b1;
                    state_d           = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Issue of address N overlaps the return of N-1, so starts are back-to-back.
                if (addr_q != LAST_ADDR) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = addr_q + 1'b1;
                    addr_d      = addr_q + 1'b1;
                end
                if (pend_q) begin
                    mem2carb_start  = 1'b1;
                    mem2carb_clause = mem_rd_data;
                    if (pend_last_q) begin
                        mem2carb_finish = 1'b1;
                        drain_d         = DW'(DRAIN_MIN);
                        state_d         = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q != '0)
                    drain_d = drain_q - 1'b1;
                else if (carb_empty)
                    state_d = ST_POP;
            end
            default: state_d = ST_IDLE;
        endcase

        if (busy && conflict) begin
            state_d = ST_CONF_DONE;
            q_flush = 1'b1;
            q_push  = 1'b0;
            q_pop   = 1'b0;
            cnt_inc = 1'b0;
        end
    end

    assign pend_d      = mem_rd_en && !(busy && conflict);
    assign pend_last_d = (mem_rd_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            drain_q     <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            round_cnt   <= '0;
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            if (cnt_clr)
                round_cnt <= '0;
            else if (cnt_inc && (round_cnt != '1))
                round_cnt <= round_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bcp_round_sched.sv
// Directed bench for bcp_round_sched: inputs driven and outputs sampled on the falling edge.
module tb_bcp_round_sched;
    import bcp_round_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    lit_t        init_uc = '0;
    logic        new_uc_valid = 1'b0;
    lit_t        new_uc = '0;
    logic        new_uc_ready;
    logic        mem_rd_en;
    logic [1:0]  mem_rd_addr;
    cla_t        mem_rd_data = '0;
    logic        mem2carb_uc_valid;
    lit_t        mem2carb_uc;
    logic        mem2carb_start;
    logic        mem2carb_finish;
    cla_t        mem2carb_clause;
    logic        carb_empty = 1'b1;
    logic        conflict = 1'b0;
    logic        busy;
    logic        sat_done;
    logic        conf_done;
    logic [15:0] round_cnt;

    cla_t mem [4];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    bcp_round_sched #(
        .NUM_CLAUSE(4),
        .UCQ_DEPTH (8),
        .DRAIN_MIN (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start_i),
        .init_uc           (init_uc),
        .new_uc_valid      (new_uc_valid),
        .new_uc            (new_uc),
        .new_uc_ready      (new_uc_ready),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_data       (mem_rd_data),
        .mem2carb_uc_valid (mem2carb_uc_valid),
        .mem2carb_uc       (mem2carb_uc),
        .mem2carb_start    (mem2carb_start),
        .mem2carb_finish   (mem2carb_finish),
        .mem2carb_clause   (mem2carb_clause),
        .carb_empty        (carb_empty),
        .conflict          (conflict),
        .busy              (busy),
        .sat_done          (sat_done),
        .conf_done         (conf_done),
        .round_cnt         (round_cnt)
    );

    function automatic cla_t mk(input int a, input int b, input int c);
        cla_t r;
        r[0] = lit_t'(a);
        r[1] = lit_t'(b);
        r[2] = lit_t'(c);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input lit_t uc);
        start_i = 1'b1;
        init_uc = uc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Waits for the POP cycle, checks the UC strobe and all four clause beats.
    task automatic expect_round(input string tag, input lit_t uc, input lit_t push_lit, output int waited);
        waited = 0;
        while (!mem2carb_uc_valid && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ucv"}, mem2carb_uc_valid, 1);
        check({tag, "_uc"}, mem2carb_uc, uc);
        check({tag, "_rd0"}, {mem_rd_en, mem_rd_addr}, {1'b1, 2'd0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) new_uc_valid = 1'b0;
            check($sformatf("%s_st%0d", tag, i), {mem2carb_start, mem2carb_finish, mem2carb_uc_valid},
                  {1'b1, (i == 3), 1'b0});
            check($sformatf("%s_cl%0d", tag, i), mem2carb_clause, mem[i]);
            if (i == 0 && push_lit != '0) begin
                new_uc_valid = 1'b1;
                new_uc       = push_lit;
            end
        end
    endtask

    task automatic wait_sat(input string tag, input logic [15:0] rounds);
        int k = 0;
        while (!sat_done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_sat"}, {sat_done, busy, conf_done}, 3'b100);
        check({tag, "_rcnt"}, round_cnt, rounds);
    endtask

    initial begin
        int   w;
        bit   popped;
        lit_t v;

        mem[0] = mk(1, 2, 7);
        mem[1] = mk(2, -1, 5);
        mem[2] = mk(0, 3, 1);
        mem[3] = mk(6, 3, 1);

        // reset state
        repeat (2) @(negedge clk);
        check("rst_out", {busy, sat_done, conf_done, mem_rd_en, mem2carb_uc_valid, mem2carb_start,
                          mem2carb_finish, new_uc_ready}, 8'b0000_0001);
        check("rst_cnt", round_cnt, 0);
        rst_n = 1'b0;
        @(negedge clk);

        // single round, exact drain timing
        v = 11'h7FF;
        start_run(v);
        expect_round("r1", v, '0, w);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check($sformatf("r1_drain%0d", j), {sat_done, mem2carb_start, mem2carb_uc_valid}, 3'b000);
        end
        @(negedge clk);
        check("r1_sat", {sat_done, busy}, 2'b10);
        check("r1_rcnt", round_cnt, 1);

        // second UC pushed during STREAM
        start_run(v);
        expect_round("r2a", v, lit_t'(3), w);
        expect_round("r2b", lit_t'(3), '0, w);
        check("r2_drain_lat", w, 4);
        wait_sat("r2", 2);

        // conflict after round 1
        mem[0] = mk(0, 3, 1);
        mem[1] = mk(0, -3, 1);
        mem[2] = '0;
        mem[3] = '0;
        start_run(lit_t'(5));
        expect_round("c1", lit_t'(5), lit_t'(7), w);
        repeat (3) @(negedge clk);
        check("c1_pre", {busy, conf_done, mem2carb_uc_valid}, 3'b100);
        conflict = 1'b1;
        @(negedge clk);
        conflict = 1'b0;
        check("c1_done", {conf_done, busy, sat_done}, 3'b100);
        check("c1_outs", {mem_rd_en, mem2carb_uc_valid, mem2carb_start, mem2carb_finish}, 4'b0000);
        check("c1_clause", mem2carb_clause, 0);
        check("c1_rcnt", round_cnt, 1);
        new_uc_valid = 1'b1;
        new_uc       = lit_t'(9);
        repeat (2) @(negedge clk);
        new_uc_valid = 1'b0;
        check("c1_level", {conf_done, new_uc_ready}, 2'b11);
        start_run(lit_t'(4));
        expect_round("c2", lit_t'(4), '0, w);
        wait_sat("c2", 1);

        // conflict with a read in flight
        start_run(lit_t'(2));
        @(negedge clk);
        conflict = 1'b1;
        @(negedge clk);
        conflict = 1'b0;
        check("c3_abort", {conf_done, mem2carb_start, mem2carb_finish, mem_rd_en}, 4'b1000);

        // carb_empty held low after finish; start while busy ignored
        mem[0] = mk(1, 2, 7);
        mem[1] = mk(2, -1, 5);
        mem[2] = mk(0, 3, 1);
        mem[3] = mk(6, 3, 1);
        carb_empty = 1'b0;
        start_run(lit_t'(6));
        expect_round("h1", lit_t'(6), lit_t'(8), w);
        popped = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (mem2carb_uc_valid) popped = 1'b1;
            start_i = (j == 3);
            init_uc = lit_t'(30);
        end
        start_i = 1'b0;
        check("h1_hold", {popped, busy}, 2'b01);
        carb_empty = 1'b1;
        @(negedge clk);
        check("h1_pop", {mem2carb_uc_valid, mem2carb_uc}, {1'b1, lit_t'(8)});
        expect_round("h2", lit_t'(8), '0, w);
        wait_sat("h2", 2);

        // UCQ fill to full, pop+push at full, FIFO order
        carb_empty = 1'b0;
        start_run(lit_t'(10));
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("f_rdy%0d", i), new_uc_ready, 1);
            new_uc_valid = 1'b1;
            new_uc       = lit_t'(21 + i);
            @(negedge clk);
        end
        check("f_full", new_uc_ready, 0);
        new_uc = lit_t'(29);
        @(negedge clk);
        check("f_hold", {new_uc_ready, busy}, 2'b01);
        carb_empty = 1'b1;
        @(negedge clk);
        check("f_pop21", {mem2carb_uc_valid, mem2carb_uc, new_uc_ready}, {1'b1, lit_t'(21), 1'b0});
        @(negedge clk);
        check("f_space", new_uc_ready, 1);
        @(negedge clk);
        new_uc_valid = 1'b0;
        check("f_refull", new_uc_ready, 0);
        for (int i = 22; i <= 29; i++)
            expect_round($sformatf("f%0d", i), lit_t'(i), '0, w);
        wait_sat("f", 10);

        // reset mid-STREAM, then a clean round
        start_run(lit_t'(12));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("x_out", {busy, sat_done, conf_done, mem_rd_en, mem2carb_uc_valid, mem2carb_start,
                        mem2carb_finish, new_uc_ready}, 8'b0000_0001);
        check("x_data", {mem2carb_clause, mem2carb_uc, mem_rd_addr, round_cnt}, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("x_quiet", {busy, mem2carb_start}, 2'b00);
        start_run(lit_t'(13));
        expect_round("x2", lit_t'(13), '0, w);
        wait_sat("x2", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
